// File: rtl/encoder_8x3_pkg.sv
// Shared widths and constants for the 8-to-3 priority encoder.
package encoder_8x3_pkg;

    localparam int ENC_IN_W   = 8;
    localparam int ENC_CODE_W = 3;

    localparam logic [ENC_CODE_W-1:0] IDLE_CODE = 3'b000;

    // Registered result; code is only meaningful while idle is low.
    typedef struct packed {
        logic                  idle;
        logic [ENC_CODE_W-1:0] code;
    } enc_result_t;

    localparam enc_result_t IDLE_RESULT = '{idle: 1'b1, code: IDLE_CODE};

endpackage

// File: rtl/encoder_8x3_core.sv
// Combinational priority search: picks the winning request bit index.
module prio_enc8_core
    import encoder_8x3_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  en,
    input  logic [ENC_IN_W-1:0]   data,
    output logic [ENC_CODE_W-1:0] code_nxt,
    output logic                  idle_nxt
);

    // The loop runs toward the highest-priority end so the last hit wins;
    // bits past the winner never reach the result.
    always_comb begin
        code_nxt = IDLE_CODE;
        idle_nxt = 1'b1;
        if (en) begin
            if (MSB_FIRST) begin
                for (int i = 0; i < ENC_IN_W; i++) begin
                    if (data[i]) begin
                        code_nxt = ENC_CODE_W'(i);
                        idle_nxt = 1'b0;
                    end
                end
            end else begin
                for (int i = ENC_IN_W - 1; i >= 0; i--) begin
                    if (data[i]) begin
                        code_nxt = ENC_CODE_W'(i);
                        idle_nxt = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/encoder_8x3.sv
// 8-input priority encoder with enable and a single registered output stage.
module encoder_8x3
    import encoder_8x3_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [ENC_IN_W-1:0]   data,
    output logic [ENC_CODE_W-1:0] code,
    output logic                  idle
);

    logic [ENC_CODE_W-1:0] code_nxt;
    logic                  idle_nxt;
    enc_result_t           result_q;

    prio_enc8_core #(
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .en       (en),
        .data     (data),
        .code_nxt (code_nxt),
        .idle_nxt (idle_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= IDLE_RESULT;
        end else begin
            result_q <= '{idle: idle_nxt, code: code_nxt};
        end
    end

    assign code = result_q.code;
    assign idle = result_q.idle;

endmodule

// File: tb/tb_encoder_8x3.sv
// Scoreboard bench: MSB-first and LSB-first instances share one stimulus stream.
module tb_encoder_8x3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] data = 8'h00;
    logic [2:0] code_m, code_l;
    logic       idle_m, idle_l;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        string      tag;
        logic [3:0] exp_m;
        logic [3:0] exp_l;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    encoder_8x3 #(.MSB_FIRST(1'b1)) dut_msb (
        .clk (clk), .rst (rst), .en (en), .data (data),
        .code (code_m), .idle (idle_m)
    );

    encoder_8x3 #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk (clk), .rst (rst), .en (en), .data (data),
        .code (code_l), .idle (idle_l)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Returns {idle, code}; index found arithmetically, not by scanning.
    function automatic logic [3:0] model(input bit msb, input logic r, input logic e,
                                         input logic [7:0] d);
        logic [8:0] d9;
        logic [7:0] iso;
        int         n;
        if (r || !e || d == 8'h00) return 4'b1_000;
        if (msb) begin
            d9 = {1'b0, d} + 9'd1;
            n  = $clog2(d9) - 1;
        end else begin
            iso = d & (~d + 8'd1);
            n   = $clog2(iso);
        end
        return {1'b0, 3'(n)};
    endfunction

    task automatic drive(input string tag, input logic r, input logic e, input logic [7:0] d);
        exp_t x;
        @(negedge clk);
        rst  = r;
        en   = e;
        data = d;
        x.tag   = tag;
        x.exp_m = model(1'b1, r, e, d);
        x.exp_l = model(1'b0, r, e, d);
        sb.push_back(x);
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk({x.tag, "_code_msb"}, {5'd0, code_m}, {5'd0, x.exp_m[2:0]});
            chk({x.tag, "_idle_msb"}, {7'd0, idle_m}, {7'd0, x.exp_m[3]});
            chk({x.tag, "_code_lsb"}, {5'd0, code_l}, {5'd0, x.exp_l[2:0]});
            chk({x.tag, "_idle_lsb"}, {7'd0, idle_l}, {7'd0, x.exp_l[3]});
        end
    end

    initial begin
        drive("reset", 1'b1, 1'b1, 8'hFF);
        drive("release", 1'b0, 1'b1, 8'hFF);
        drive("disable", 1'b0, 1'b0, 8'hFF);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] one;
            one = 8'h01 << i;
            drive($sformatf("walk%0d", i), 1'b0, 1'b1, one);
        end
        drive("zero", 1'b0, 1'b1, 8'h00);
        drive("prio", 1'b0, 1'b1, 8'b0101_0011);
        drive("prio_hi", 1'b0, 1'b1, 8'b0010_1100);
        drive("stream0", 1'b0, 1'b1, 8'h80);
        drive("stream1", 1'b0, 1'b1, 8'h80);
        drive("mid_rst", 1'b1, 1'b1, 8'h80);
        drive("resume", 1'b0, 1'b1, 8'h80);
        for (int i = 0; i < 6; i++) begin
            drive($sformatf("toggle%0d", i), 1'b0, ~i[0], 8'h10);
        end
        for (int i = 0; i < 40; i++) begin
            logic       r;
            logic       e;
            logic [7:0] d;
            r = ($urandom_range(0, 9) == 0);
            e = ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            drive($sformatf("rand%0d", i), r, e, d);
        end
        repeat (3) @(negedge clk);
        chk("drain", 8'(sb.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
